instr_encoder: RTL and testbench

//  Inverse of the decode stage: turns a structured encode request (kind, rd, rs1, rs2, f3, imm) into
//  RV64I 32-bit instruction words. Expands pseudo-op LI into ADDI, LUI, or LUI+ADDIW.

---
 rtl/enc_pkg.sv | 89 ++++++++
 rtl/enc_format.sv | 113 +++++++++++
 rtl/instr_encoder.sv | 115 +++++++++++
 tb/tb_instr_encoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared encoder types, opcodes and RV64I word-format helpers.
// Used by enc_format (word construction) and instr_encoder (FSM top).
package enc_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 32;

  // Request kinds; codes 12..15 are undefined and encode as NOP with err.
  typedef enum logic [3:0] {
    K_OPIMM  = 4'd0,
    K_OPIMMW = 4'd1,
    K_LOAD   = 4'd2,
    K_JALR   = 4'd3,
    K_OP     = 4'd4,
    K_OPW    = 4'd5,
    K_STORE  = 4'd6,
    K_BRANCH = 4'd7,
    K_JAL    = 4'd8,
    K_LUI    = 4'd9,
    K_AUIPC  = 4'd10,
    K_LI     = 4'd11
  } enc_kind_t;

  typedef struct packed {
    enc_kind_t          kind;
    logic [2:0]         f3;
    logic               alt;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [IMM_W-1:0]   imm;
  } enc_req_t;

  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OPIMMW = 7'h1B;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPW    = 7'h3B;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [5:0] F6_BASE = 6'h00;
  localparam logic [5:0] F6_ALT  = 6'h10;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

  function automatic logic [31:0] fmt_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] fmt_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] fmt_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // Branch offsets are always even, so bit 0 is not carried.
  function automatic logic [31:0] fmt_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] fmt_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] fmt_j(input logic [20:1] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

endpackage

// File: rtl/enc_format.sv
// Combinational request-to-word mapper.
// Ports: req_i (request), word0_o (first word), word1_o (queued ADDIW of a
// two-word LI), two_words_o (word1_o is valid), err0_o (range/kind error).
module enc_format
  import enc_pkg::*;
#(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  enc_req_t     req_i,
  output logic [31:0]  word0_o,
  output logic [31:0]  word1_o,
  output logic         two_words_o,
  output logic         err0_o
);

  logic signed [31:0] simm;
  logic               fits_i;
  logic               fits_b;
  logic               fits_j;
  logic               fits_u;
  logic               is_shift;
  logic [5:0]         f6;
  logic [6:0]         f7;
  logic [19:0]        li_hi;
  logic               range_bad;
  logic               kind_bad;

  assign simm     = $signed(req_i.imm);
  assign fits_i   = (simm >= -32'sd2048) && (simm <= 32'sd2047);
  assign fits_b   = (simm >= -32'sd4096) && (simm <= 32'sd4095) && !req_i.imm[0];
  assign fits_j   = (simm >= -32'sd1048576) && (simm <= 32'sd1048575) && !req_i.imm[0];
  // Accept either an unsigned or a sign-extended 20-bit value.
  assign fits_u   = (req_i.imm[31:20] == 12'h000) || (req_i.imm[31:19] == 13'h1FFF);
  assign is_shift = (req_i.f3 == 3'b001) || (req_i.f3 == 3'b101);
  assign f6       = req_i.alt ? F6_ALT : F6_BASE;
  assign f7       = req_i.alt ? F7_ALT : F7_BASE;
  // Rounded upper part so that LUI hi + sext(lo) reconstructs imm (mod 2^32).
  assign li_hi    = 20'((req_i.imm + 32'h0000_0800) >> 12);

  // Per-kind word construction and range classification.
  always_comb begin
    word0_o     = NOP_WORD;
    word1_o     = '0;
    two_words_o = 1'b0;
    range_bad   = 1'b0;
    kind_bad    = 1'b0;
    case (req_i.kind)
      K_OPIMM: begin
        if (is_shift) begin
          word0_o   = fmt_i({f6, req_i.imm[5:0]}, req_i.rs1, req_i.f3, req_i.rd, OPC_OPIMM);
          range_bad = |req_i.imm[31:6];
        end else begin
          word0_o   = fmt_i(req_i.imm[11:0], req_i.rs1, req_i.f3, req_i.rd, OPC_OPIMM);
          range_bad = !fits_i;
        end
      end
      K_OPIMMW: begin
        if (is_shift) begin
          word0_o   = fmt_i({f6, 1'b0, req_i.imm[4:0]}, req_i.rs1, req_i.f3, req_i.rd,
                            OPC_OPIMMW);
          range_bad = |req_i.imm[31:5];
        end else begin
          word0_o   = fmt_i(req_i.imm[11:0], req_i.rs1, req_i.f3, req_i.rd, OPC_OPIMMW);
          range_bad = !fits_i;
        end
      end
      K_LOAD: begin
        word0_o   = fmt_i(req_i.imm[11:0], req_i.rs1, req_i.f3, req_i.rd, OPC_LOAD);
        range_bad = !fits_i;
      end
      K_JALR: begin
        word0_o   = fmt_i(req_i.imm[11:0], req_i.rs1, req_i.f3, req_i.rd, OPC_JALR);
        range_bad = !fits_i;
      end
      K_OP:  word0_o = fmt_r(f7, req_i.rs2, req_i.rs1, req_i.f3, req_i.rd, OPC_OP);
      K_OPW: word0_o = fmt_r(f7, req_i.rs2, req_i.rs1, req_i.f3, req_i.rd, OPC_OPW);
      K_STORE: begin
        word0_o   = fmt_s(req_i.imm[11:0], req_i.rs2, req_i.rs1, req_i.f3, OPC_STORE);
        range_bad = !fits_i;
      end
      K_BRANCH: begin
        word0_o   = fmt_b(req_i.imm[12:1], req_i.rs2, req_i.rs1, req_i.f3, OPC_BRANCH);
        range_bad = !fits_b;
      end
      K_JAL: begin
        word0_o   = fmt_j(req_i.imm[20:1], req_i.rd, OPC_JAL);
        range_bad = !fits_j;
      end
      K_LUI: begin
        word0_o   = fmt_u(req_i.imm[19:0], req_i.rd, OPC_LUI);
        range_bad = !fits_u;
      end
      K_AUIPC: begin
        word0_o   = fmt_u(req_i.imm[19:0], req_i.rd, OPC_AUIPC);
        range_bad = !fits_u;
      end
      K_LI: begin
        if (fits_i) begin
          word0_o = fmt_i(req_i.imm[11:0], 5'd0, 3'd0, req_i.rd, OPC_OPIMM);
        end else if (req_i.imm[11:0] == 12'h000) begin
          word0_o = fmt_u(li_hi, req_i.rd, OPC_LUI);
        end else begin
          word0_o     = fmt_u(li_hi, req_i.rd, OPC_LUI);
          word1_o     = fmt_i(req_i.imm[11:0], req_i.rd, 3'd0, req_i.rd, OPC_OPIMMW);
          two_words_o = 1'b1;
        end
      end
      default: kind_bad = 1'b1;
    endcase
    err0_o = kind_bad | (CHECK_RANGE & range_bad);
  end

endmodule

// File: rtl/instr_encoder.sv
// Encode-request to RV64I word stream with valid/ready on both sides.
// Ports: clk, reset (async, active-high), req_valid/req_ready/req (request
// side), instr_valid/instr_ready/instr/instr_last/err (word side).
module instr_encoder
  import enc_pkg::*;
#(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  enc_req_t     req,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr,
  output logic         instr_last,
  output logic         err
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_PEND  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q,  last_d;
  logic        err_q,   err_d;
  logic [31:0] pend_q,  pend_d;

  logic [31:0] word0;
  logic [31:0] word1;
  logic        two_words;
  logic        err0;
  logic        accept;

  enc_format #(.CHECK_RANGE(CHECK_RANGE)) u_fmt (
    .req_i       (req),
    .word0_o     (word0),
    .word1_o     (word1),
    .two_words_o (two_words),
    .err0_o      (err0)
  );

  // A held word can be replaced in the same cycle it is consumed.
  assign req_ready = (state_q == S_EMPTY) || ((state_q == S_FULL) && instr_ready);
  assign accept    = req_valid && req_ready;

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
    pend_d  = pend_q;
    case (state_q)
      S_EMPTY, S_FULL: begin
        if ((state_q == S_FULL) && instr_ready) begin
          state_d = S_EMPTY;
          valid_d = 1'b0;
          instr_d = '0;
          last_d  = 1'b0;
          err_d   = 1'b0;
        end
        if (accept) begin
          state_d = two_words ? S_PEND : S_FULL;
          valid_d = 1'b1;
          instr_d = word0;
          last_d  = !two_words;
          err_d   = err0;
          if (two_words) pend_d = word1;
        end
      end
      S_PEND: begin
        if (instr_ready) begin
          state_d = S_FULL;
          instr_d = pend_q;
          last_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_EMPTY;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      valid_q <= 1'b0;
      instr_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_last  = last_q;
  assign err         = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued as requests
// are driven and compared at each word handoff.
module tb_instr_encoder;
  import enc_pkg::*;

  typedef struct {
    logic [31:0] word;
    logic        last;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  enc_req_t    req;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_last;
  logic        err;

  exp_t sb[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;

  instr_encoder #(.CHECK_RANGE(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req         (req),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_last  (instr_last),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Word handoff monitor: inputs are stable from posedge+1 to the next posedge.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got word %h last=%b err=%b with nothing expected",
                 instr, instr_last, err);
      end else begin
        mon_x = sb.pop_front();
        if (instr !== mon_x.word || instr_last !== mon_x.last || err !== mon_x.err) begin
          errors++;
          $display("FAIL sb_word: got %h last=%b err=%b, expected %h last=%b err=%b",
                   instr, instr_last, err, mon_x.word, mon_x.last, mon_x.err);
        end
      end
    end
  end

  function automatic enc_req_t mk(input enc_kind_t k, input logic [2:0] f3, input logic alt,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm);
    enc_req_t r;
    r.kind = k; r.f3 = f3; r.alt = alt; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  task automatic push(input logic [31:0] w, input logic l, input logic e);
    exp_t x;
    x.word = w; x.last = l; x.err = e;
    sb.push_back(x);
  endtask

  // Present a request until accepted; returns at posedge+1 after acceptance.
  task automatic do_req(input enc_req_t r, output int tries);
    logic acc;
    req = r; req_valid = 1'b1; tries = 0; acc = 1'b0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = req_ready;
      tries++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL req_timeout: request not accepted within %0d cycles", tries);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_last !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b instr=%h last=%b err=%b, expected 0/0/0/0",
               instr_valid, instr, instr_last, err);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got req_ready=%b, expected 1", req_ready);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_itype;
    int t;
    instr_ready = 1'b1;
    push(32'hFFF00293, 1'b1, 1'b0);
    do_req(mk(K_OPIMM, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, -32'sd1), t);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hFFF00293 || instr_last !== 1'b1) begin
      errors++;
      $display("FAIL itype_latency: got valid=%b instr=%h last=%b, expected 1/fff00293/1",
               instr_valid, instr, instr_last);
    end
    idle(2);
  endtask

  task automatic test_formats;
    int t;
    instr_ready = 1'b1;
    push(32'h402081B3, 1'b1, 1'b0);
    do_req(mk(K_OP, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0), t);
    push(32'h00208463, 1'b1, 1'b0);
    do_req(mk(K_BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8), t);
    push(32'h00513823, 1'b1, 1'b0);
    do_req(mk(K_STORE, 3'd3, 1'b0, 5'd0, 5'd2, 5'd5, 32'd16), t);
    push(32'h43F0D093, 1'b1, 1'b0);
    do_req(mk(K_OPIMM, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd63), t);
    push(32'h80013203, 1'b1, 1'b0);
    do_req(mk(K_LOAD, 3'd3, 1'b0, 5'd4, 5'd2, 5'd0, -32'sd2048), t);
    push(32'hFFFFF06F, 1'b1, 1'b0);
    do_req(mk(K_JAL, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd2), t);
    push(32'h12345117, 1'b1, 1'b0);
    do_req(mk(K_AUIPC, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h12345), t);
    idle(3);
  endtask

  task automatic test_li;
    int t;
    instr_ready = 1'b1;
    push(32'h12345537, 1'b0, 1'b0);
    push(32'h6785051B, 1'b1, 1'b0);
    do_req(mk(K_LI, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h12345678), t);
    checks++;
    if (req_ready !== 1'b0 || instr !== 32'h12345537 || instr_last !== 1'b0) begin
      errors++;
      $display("FAIL li_pend: got req_ready=%b instr=%h last=%b, expected 0/12345537/0",
               req_ready, instr, instr_last);
    end
    push(32'h000010B7, 1'b0, 1'b0);
    push(32'h8000809B, 1'b1, 1'b0);
    do_req(mk(K_LI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800), t);
    push(32'h000010B7, 1'b1, 1'b0);
    do_req(mk(K_LI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1000), t);
    push(32'hFFB00113, 1'b1, 1'b0);
    do_req(mk(K_LI, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, -32'sd5), t);
    push(32'h800000B7, 1'b0, 1'b0);
    push(32'h8000809B, 1'b1, 1'b0);
    do_req(mk(K_LI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h7FFFF800), t);
    idle(4);
  endtask

  task automatic test_backpressure;
    int t;
    logic [31:0] imm;
    logic [4:0]  rd;
    instr_ready = 1'b0;
    push(32'h06400313, 1'b1, 1'b0);
    do_req(mk(K_OPIMM, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'd100), t);
    req = mk(K_OPIMM, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd1);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h06400313 || instr_last !== 1'b1 ||
          err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b instr=%h last=%b err=%b ready=%b, expected 1/06400313/1/0/0",
                 i, instr_valid, instr, instr_last, err, req_ready);
      end
    end
    req_valid = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imm = 32'(i * 3 - 4);
      rd  = 5'(8 + i);
      push({imm[11:0], 5'd0, 3'd0, rd, 7'h13}, 1'b1, 1'b0);
      do_req(mk(K_OPIMM, 3'd0, 1'b0, rd, 5'd0, 5'd0, imm), t);
      checks++;
      if (t != 1) begin
        errors++;
        $display("FAIL b2b_rate[%0d]: got %0d cycles to accept, expected 1", i, t);
      end
    end
    idle(3);
  endtask

  task automatic test_err;
    int t;
    instr_ready = 1'b1;
    push(32'h00208363, 1'b1, 1'b1);
    do_req(mk(K_BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7), t);
    push(32'h80000293, 1'b1, 1'b1);
    do_req(mk(K_OPIMM, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd2048), t);
    push(32'h00000013, 1'b1, 1'b1);
    do_req(mk(enc_kind_t'(4'hF), 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0), t);
    push(32'h800000EF, 1'b1, 1'b1);
    do_req(mk(K_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h100000), t);
    push(32'h0000909B, 1'b1, 1'b1);
    do_req(mk(K_OPIMMW, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32), t);
    push(32'h000000B7, 1'b1, 1'b1);
    do_req(mk(K_LUI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h100000), t);
    idle(3);
  endtask

  task automatic test_reset_mid_li;
    int t;
    instr_ready = 1'b0;
    do_req(mk(K_LI, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h12345678), t);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h12345537 || instr_last !== 1'b0) begin
      errors++;
      $display("FAIL midli_lui: got valid=%b instr=%h last=%b, expected 1/12345537/0",
               instr_valid, instr, instr_last);
    end
    reset = 1'b1;
    idle(1);
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_last !== 1'b0) begin
      errors++;
      $display("FAIL midli_reset: got valid=%b instr=%h last=%b, expected 0/0/0",
               instr_valid, instr, instr_last);
    end
    reset = 1'b0;
    instr_ready = 1'b1;
    idle(6);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL midli_no_addiw: got valid=%b instr=%h, expected valid=0", instr_valid, instr);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    req_valid = 1'b0;
    instr_ready = 1'b0;
    req = '0;
    test_reset();
    test_itype();
    test_formats();
    test_li();
    test_backpressure();
    test_err();
    test_reset_mid_li();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d words still expected, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
